// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: producer/consumer bus bundle for stream_mux_rr.
// in_last exists only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_rr_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
`ifdef STREAM_MUX_LOCK_EN
    logic [N-1:0]     in_last;
`endif
    logic             force_en;
    logic [SEL_W-1:0] force_sel;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;

    // Mux side
    modport slave (
`ifdef STREAM_MUX_LOCK_EN
        input  in_last,
`endif
        input  in_data,
        input  in_valid,
        output in_ready,
        input  force_en,
        input  force_sel,
        output out_data,
        output out_sel,
        output out_valid,
        input  out_ready
    );

    // Environment side (producers + consumer)
    modport master (
`ifdef STREAM_MUX_LOCK_EN
        output in_last,
`endif
        output in_data,
        output in_valid,
        input  in_ready,
        output force_en,
        output force_sel,
        input  out_data,
        input  out_sel,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with round-robin or
// forced channel select and a registered output stage sustaining one beat
// per cycle under back-pressure.
// Optional feature: define STREAM_MUX_LOCK_EN to hold the grant on a channel
// until it delivers a beat with in_last set (packet lock).
module stream_mux_rr #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [SEL_W-1:0] rr_ptr;
    logic [W-1:0]     out_data_q;
    logic [SEL_W-1:0] out_sel_q;
    logic             out_valid_q;

    logic             load;
    logic             accept;
    logic             hi_vld;
    logic             lo_vld;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             fs_vld;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_data;

`ifdef STREAM_MUX_LOCK_EN
    typedef enum logic {ARB, LOCKED} lock_state_t;
    lock_state_t      lock_state;
    logic [SEL_W-1:0] lock_ch;
    logic             lk_vld;
    logic             gnt_last;
`endif

    // Round-robin search: lowest valid channel above rr_ptr, else lowest valid at or below it
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (SEL_W'(i) > rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = SEL_W'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = SEL_W'(i);
                end
            end
        end
        rr_vld = hi_vld | lo_vld;
        rr_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Forced candidate: force_sel outside 0..N-1 never matches, so it never grants
    always_comb begin
        fs_vld = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.force_sel == SEL_W'(i) && bus.in_valid[i]) fs_vld = 1'b1;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // Locked channel still presenting data
    always_comb begin
        lk_vld = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (lock_ch == SEL_W'(i) && bus.in_valid[i]) lk_vld = 1'b1;
        end
    end

    // End-of-packet flag of the granted channel
    always_comb begin
        gnt_last = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_last = bus.in_last[i];
        end
    end
`endif

    // Grant selection: lock overrides force, force overrides round-robin
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifdef STREAM_MUX_LOCK_EN
        if (lock_state == LOCKED) begin
            gnt_vld = lk_vld;
            gnt_idx = lock_ch;
        end else
`endif
        if (bus.force_en) begin
            gnt_vld = fs_vld;
            gnt_idx = bus.force_sel;
        end else begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end
    end

    // Data word of the granted channel
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*W +: W];
        end
    end

    // Output register can take a new beat when empty or draining this cycle
    assign load   = !out_valid_q || bus.out_ready;
    assign accept = gnt_vld && load && !rst;

    // One-hot ready toward the granted producer only
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (accept && gnt_idx == SEL_W'(i)) bus.in_ready[i] = 1'b1;
        end
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr      <= SEL_W'(N - 1);
        end else if (load) begin
            if (gnt_vld) begin
                out_data_q  <= gnt_data;
                out_sel_q   <= gnt_idx;
                out_valid_q <= 1'b1;
                rr_ptr      <= gnt_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock FSM: a non-last beat locks its channel, a last beat releases
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= ARB;
            lock_ch    <= '0;
        end else if (accept) begin
            if (gnt_last) begin
                lock_state <= ARB;
            end else begin
                lock_state <= LOCKED;
                lock_ch    <= gnt_idx;
            end
        end
    end
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scenario tasks plus randomized traffic checked against a
// cycle-level behavioural model of the mux rules and a per-channel scoreboard.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [W-1:0] chd [N];
    int           sent [N];
    int           rcv [N];

    // Behavioural model state
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_os;
    logic         m_lock;
    int           m_lch;

    stream_mux_rr_if #(.N(N), .W(W)) bus ();

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel the model would grant now, -1 for none
    function automatic int m_grant();
        logic [N-1:0] v;
        int c;
        v = bus.in_valid;
        if (rst) return -1;
`ifdef STREAM_MUX_LOCK_EN
        if (m_lock) return v[SW'(m_lch)] ? m_lch : -1;
`endif
        if (bus.force_en) begin
            if (int'(bus.force_sel) < N && v[bus.force_sel]) return int'(bus.force_sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (v[SW'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0 && (!m_ov || bus.out_ready)) r[SW'(g)] = 1'b1;
        return r;
    endfunction

    // Advance the model across one clock edge using the current inputs
    function automatic void m_step();
        int g;
        g = m_grant();
        if (rst) begin
            m_ptr  = N - 1;
            m_ov   = 1'b0;
            m_od   = '0;
            m_os   = 0;
            m_lock = 1'b0;
            m_lch  = 0;
        end else if (!m_ov || bus.out_ready) begin
            if (g >= 0) begin
                m_od  = W'(bus.in_data >> (g * W));
                m_os  = g;
                m_ov  = 1'b1;
                m_ptr = g;
`ifdef STREAM_MUX_LOCK_EN
                m_lock = !bus.in_last[SW'(g)];
                m_lch  = g;
`endif
            end else begin
                m_ov = 1'b0;
            end
        end
    endfunction

    task automatic settle();
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = chd[i];
        #1;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b0;
        settle();
        tick();
        tick();
        n_tests++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_tests++; if (bus.out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", bus.out_sel); end
        rst = 1'b0;
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_tests++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0000", bus.in_ready); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] er;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) chd[i] = W'(8'hA0 + i);
        for (int c = 0; c < 8; c++) begin
            settle();
            er = '0;
            er[SW'(c % N)] = 1'b1;
            n_tests++; if (bus.in_ready !== er) begin n_fail++; $display("FAIL rr_in_ready: got %b want %b", bus.in_ready, er); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_out_valid: got %b want 1", bus.out_valid); end
            n_tests++; if (bus.out_sel !== SW'(c % N)) begin n_fail++; $display("FAIL rr_out_sel: got %0d want %0d", bus.out_sel, c % N); end
            n_tests++; if (bus.out_data !== W'(8'hA0 + c % N)) begin n_fail++; $display("FAIL rr_out_data: got %h want %h", bus.out_data, W'(8'hA0 + c % N)); end
        end
    endtask

    task automatic test_back_pressure();
        logic [N-1:0] er;
        int sel;
        logic [W-1:0] ed;
        // One beat from channel 0, then stall for three cycles
        settle();
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_tests++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0000", bus.in_ready); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0) begin
                n_fail++; $display("FAIL bp_hold: got v=%b sel=%0d data=%h want v=1 sel=0 data=a0", bus.out_valid, bus.out_sel, bus.out_data); end
        end
        bus.out_ready = 1'b1;
        settle();
        n_tests++; if (bus.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0010", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 8'hA1) begin
            n_fail++; $display("FAIL bp_release_beat: got v=%b sel=%0d data=%h want v=1 sel=1 data=a1", bus.out_valid, bus.out_sel, bus.out_data); end

        // Randomized traffic with per-channel sequence scoreboard
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            rcv[i]  = 0;
        end
        // Flush the pending beat so the scoreboard starts empty
        bus.in_valid = 4'b0000;
        settle();
        tick();
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = N'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) chd[i] = {SW'(i), 6'(sent[i])};
            settle();
            er = m_ready();
            n_tests++; if (bus.in_ready !== er) begin n_fail++; $display("FAIL rand_in_ready: cyc %0d got %b want %b", c, bus.in_ready, er); end
            n_tests++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rand_out_valid: cyc %0d got %b want %b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                n_tests++; if (bus.out_sel !== SW'(m_os) || bus.out_data !== m_od) begin
                    n_fail++; $display("FAIL rand_out_beat: cyc %0d got sel=%0d data=%h want sel=%0d data=%h", c, bus.out_sel, bus.out_data, m_os, m_od); end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                sel = int'(bus.out_sel);
                ed  = {SW'(sel), 6'(rcv[sel])};
                n_tests++; if (bus.out_data !== ed) begin n_fail++; $display("FAIL sb_seq: ch %0d got %h want %h", sel, bus.out_data, ed); end
                rcv[sel]++;
            end
            for (int i = 0; i < N; i++) if (er[i] && bus.in_valid[i]) sent[i]++;
            tick();
        end
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            if (bus.out_valid === 1'b1) begin
                sel = int'(bus.out_sel);
                ed  = {SW'(sel), 6'(rcv[sel])};
                n_tests++; if (bus.out_data !== ed) begin n_fail++; $display("FAIL sb_drain: ch %0d got %h want %h", sel, bus.out_data, ed); end
                rcv[sel]++;
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            n_tests++; if (rcv[i] !== sent[i]) begin n_fail++; $display("FAIL sb_count: ch %0d got %0d beats want %0d", i, rcv[i], sent[i]); end
        end
    endtask

    task automatic test_forced();
        bus.force_en  = 1'b1;
        bus.force_sel = 2'd2;
        bus.in_valid  = 4'b1010;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) chd[i] = W'(8'h30 + i);
        for (int c = 0; c < 2; c++) begin
            settle();
            n_tests++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL force_nogrant_ready: got %b want 0000", bus.in_ready); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL force_nogrant_valid: got %b want 0", bus.out_valid); end
        end
        bus.in_valid = 4'b1110;
        chd[2] = 8'h55;
        settle();
        n_tests++; if (bus.in_ready !== 4'b0100) begin n_fail++; $display("FAIL force_ready: got %b want 0100", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 8'h55) begin
            n_fail++; $display("FAIL force_beat: got v=%b sel=%0d data=%h want v=1 sel=2 data=55", bus.out_valid, bus.out_sel, bus.out_data); end
        // Round-robin resumes after the forced grant
        bus.force_en = 1'b0;
        bus.in_valid = 4'b1111;
        settle();
        n_tests++; if (bus.in_ready !== 4'b1000) begin n_fail++; $display("FAIL force_resume_ready: got %b want 1000", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_sel !== 2'd3 || bus.out_data !== 8'h33) begin
            n_fail++; $display("FAIL force_resume_beat: got sel=%0d data=%h want sel=3 data=33", bus.out_sel, bus.out_data); end
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic test_lock();
        int exp_sel [4];
        exp_sel = '{1, 1, 1, 0};
        bus.force_en  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_last   = 4'b1111;
        bus.in_valid  = 4'b0001;
        chd[0] = 8'h01;
        settle();
        tick();
        bus.in_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            chd[1] = W'(8'h10 + b);
            bus.in_last[1] = (b == 2);
            settle();
            tick();
            n_tests++; if (bus.out_sel !== SW'(exp_sel[b])) begin n_fail++; $display("FAIL lock_sel: beat %0d got %0d want %0d", b, bus.out_sel, exp_sel[b]); end
            if (b < 3) begin
                n_tests++; if (bus.out_data !== W'(8'h10 + b)) begin n_fail++; $display("FAIL lock_data: beat %0d got %h want %h", b, bus.out_data, W'(8'h10 + b)); end
            end
        end
        bus.in_last = 4'b1111;
    endtask
`endif

    task automatic test_reset_mid();
        bus.force_en  = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) chd[i] = W'(8'hC0 + i);
        settle();
        tick();
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        settle();
        n_tests++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0000", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h00) begin
            n_fail++; $display("FAIL midrst_state: got v=%b sel=%0d data=%h want v=0 sel=0 data=00", bus.out_valid, bus.out_sel, bus.out_data); end
        rst = 1'b0;
        bus.in_valid  = 4'b0110;
        bus.out_ready = 1'b1;
        settle();
        n_tests++; if (bus.in_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_first_ready: got %b want 0010", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 8'hC1) begin
            n_fail++; $display("FAIL midrst_first_beat: got v=%b sel=%0d data=%h want v=1 sel=1 data=c1", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ptr   = N - 1;
        m_ov    = 1'b0;
        m_od    = '0;
        m_os    = 0;
        m_lock  = 1'b0;
        m_lch   = 0;
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.force_en  = 1'b0;
        bus.force_sel = '0;
        bus.out_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
        bus.in_last   = '1;
`endif
        for (int i = 0; i < N; i++) chd[i] = '0;
        settle();

        test_reset();
        test_round_robin();
        test_back_pressure();
        test_forced();
`ifdef STREAM_MUX_LOCK_EN
        test_lock();
`endif
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. It is the sequential successor of the combinational N:1 bit mux: each channel carries a full data word, the select is either generated internally (fair round-robin) or forced externally, and one beat per cycle is sustained under back-pressure. It sits between multiple producer streams and a single shared consumer.

## Interface
- N, 16: number of input channels, N >= 2.
- W, 8: data width per channel.
- SEL_W, $clog2(N): channel index width, derived; do not override.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- force_en  input  1  1 = fixed-select mode, 0 = round-robin mode.
- force_sel  input  SEL_W  channel used when force_en = 1.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  channel index of the beat in out_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.
- in_last  input  N  per-channel end-of-packet; present only with STREAM_MUX_LOCK_EN.

## Operation
- Internal state: rr_ptr (last granted channel), output register (out_data, out_sel, out_valid), lock flag plus locked channel (lock build only).
- Load enable: load = !out_valid || out_ready.
- Grant, combinational:
  - Round-robin: the first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N.
  - Forced: force_sel, if in_valid[force_sel].
  - No grant if no candidate is valid.
- in_ready[g] = load for the granted channel g. All other in_ready bits are 0.
- Input accept = in_valid[g] && in_ready[g]. On accept: out_data <= channel g data; out_sel <= g; out_valid <= 1; rr_ptr <= g.
- If load is high and no accept occurs: out_valid <= 0. out_data and out_sel hold.
- If out_valid && !out_ready: the output register holds, all in_ready bits are 0, and out_data/out_sel stay stable.
- force_sel >= N (when N is not a power of 2): no grant, and all in_ready bits are 0.
- Switching force_en affects the next grant computation only. rr_ptr continues from the last accepted channel.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, in_ready all 0 during the reset cycle, rr_ptr N-1 (the first round-robin search starts at channel 0), lock cleared.
- Latency: an accept at edge k gives out_valid = 1 with that data after edge k.
- Throughput: one beat per cycle while out_ready = 1. Simultaneous drain and refill in the same cycle is required (no bubble).
- in_ready depends combinationally on out_valid, out_ready, in_valid, force_en, force_sel and state. There is no combinational path from in_data to any output.
- Reset asserted mid-transfer: the in-flight output beat is discarded, state returns to reset values on that edge, and in_ready is 0 that cycle.

## Configuration
- STREAM_MUX_LOCK_EN defined:
  - The in_last port exists.
  - Accepting a beat with in_last[g] = 0 sets lock on channel g.
  - While locked, grant is only the locked channel, regardless of other valids, force_en or force_sel.
  - Accepting a beat with in_last = 1 clears lock. Single-beat packets never lock.
  - Reset clears lock.
- Undefined: the in_last port is absent, and arbitration is re-evaluated on every beat.

## Test plan
- Reset then idle, N=4, W=8: all outputs 0, in_ready = 4'b0000 with no valids, out_valid stays 0.
- Round-robin fairness, N=4: in_valid = 4'b1111 constant, channel i data = 8'hA0+i, out_ready = 1 -> out_sel sequence 0,1,2,3,0,... with matching data, one beat per cycle.
- Back-pressure: out_ready low for 3 cycles with out_valid = 1 -> out_data/out_sel stable, in_ready = 0. On release, the next beat follows with no gap and no lost or duplicated beat (scoreboard per channel).
- Forced mode: force_en = 1, force_sel = 2, only channels 1 and 3 valid -> no grant, out_valid 0. Then raise in_valid[2] with data 8'h55 -> out_data 8'h55, out_sel 2 one cycle later.
- Lock (STREAM_MUX_LOCK_EN): channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> out_sel 1,1,1 then 0.
- Reset mid-stream with out_valid = 1 and out_ready = 0 -> after the edge out_valid 0 and out_sel 0, and the first grant afterwards is the lowest valid channel.
